// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: iterates COLS_PER_CYCLE columns per clock
// over a captured 128-bit state, with ready/valid handshakes on both sides.

module mix_col #(
    parameter bit INV_EN = 1'b1
) (
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] res
);
    logic [0:3][7:0] a, m2, f, v;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign a = col;

    // row r of a circulant: coefficient k multiplies a[(r+k)%4]
    for (genvar r = 0; r < 4; r++) begin : g_fwd
        assign m2[r] = xt(a[r]);
        assign f[r]  = m2[r] ^ m2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end

    if (INV_EN) begin : g_inv
        logic [0:3][7:0] m4, m8;
        for (genvar r = 0; r < 4; r++) begin : g_b
            assign m4[r] = xt(m2[r]);
            assign m8[r] = xt(m4[r]);
            assign v[r]  = (m8[r] ^ m4[r] ^ m2[r])
                         ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ a[(r+1)%4])
                         ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ a[(r+2)%4])
                         ^ (m8[(r+3)%4] ^ a[(r+3)%4]);
        end
    end else begin : g_noinv
        assign v = '0;
    end

    assign res = (INV_EN && inv) ? v : f;
endmodule

module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INVERSE_EN     = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

    st_t             st, st_nxt;
    logic [1:0]      cnt;
    logic [127:0]    work;
    logic            mode, live, accept, last;
    logic [0:3][31:0] wcol, col_out, upd;

    assign wcol   = work;
    assign accept = in_valid && in_ready;
    assign last   = (cnt == 2'(4 - COLS_PER_CYCLE));

    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (g < COLS_PER_CYCLE) begin : g_on
            mix_col #(.INV_EN(INVERSE_EN)) u_col (
                .col(wcol[cnt + 2'(g)]),
                .inv(mode),
                .res(col_out[g])
            );
        end else begin : g_off
            assign col_out[g] = '0;
        end
    end

    // column c takes lane (c - cnt) when that lane lies inside this cycle's group
    for (genvar c = 0; c < 4; c++) begin : g_upd
        logic [1:0] off;
        assign off    = 2'(c) - cnt;
        assign upd[c] = ({1'b0, off} < 3'(COLS_PER_CYCLE)) ? col_out[off] : wcol[c];
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE: if (accept) st_nxt = BUSY;
            BUSY: if (last) st_nxt = DONE;
            DONE: if (out_ready) st_nxt = in_valid ? BUSY : IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st   <= IDLE;
            cnt  <= '0;
            work <= '0;
            mode <= 1'b0;
            live <= 1'b0;
        end else begin
            live <= 1'b1;
            st   <= st_nxt;
            if (accept) begin
                work <= in_state;
                mode <= in_inverse && INVERSE_EN;
                cnt  <= '0;
            end else if (st == BUSY) begin
                work <= upd;
                cnt  <= cnt + 2'(COLS_PER_CYCLE);
            end
        end
    end

    // live keeps in_ready low during reset and until the first clock after release
    assign in_ready  = live && ((st == IDLE) || (st == DONE && out_ready));
    assign out_valid = (st == DONE);
    assign busy      = (st == BUSY);
    assign out_state = work;
endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: four instances (1/2/4 columns per cycle,
// and a forward-only build) driven one at a time against known AES vectors.
module tb_mix_columns_engine;
    logic         clk, rst_n;
    logic         iv[4], ir[4], ii[4], ov[4], ordy[4], bz[4];
    logic [127:0] is_[4], os[4];
    int           checks, errors, cyc;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        mix_columns_engine #(
            .COLS_PER_CYCLE(k == 1 ? 2 : (k == 2 ? 4 : 1)),
            .INVERSE_EN(k == 3 ? 1'b0 : 1'b1)
        ) u_dut (
            .clock(clk), .reset_n(rst_n),
            .in_valid(iv[k]), .in_ready(ir[k]), .in_state(is_[k]), .in_inverse(ii[k]),
            .out_valid(ov[k]), .out_ready(ordy[k]), .out_state(os[k]), .busy(bz[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    localparam logic [127:0] VX = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] VY = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] VZ = 128'hd4d4d4d5_c6c6c6c6_01010101_d4d4d4d5;
    localparam logic [127:0] VW = 128'hd5d5d7d6_c6c6c6c6_01010101_d5d5d7d6;
    localparam logic [127:0] VC = {4{32'hc6c6c6c6}};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int nbusy(input int k);
        return (k == 1) ? 2 : ((k == 2) ? 1 : 4);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int k, input logic [127:0] st, input logic inv,
                       input int stall, output logic [127:0] res);
        int n;
        n = 0;
        while (!ir[k] && n < 20) begin step; n++; end
        chk($sformatf("rdy%0d", k), ir[k], 1);
        iv[k] = 1; is_[k] = st; ii[k] = inv; ordy[k] = (stall == 0);
        step;
        iv[k] = 0; is_[k] = ~st; ii[k] = ~inv;
        n = 1;
        while (!ov[k] && n < 20) begin step; n++; end
        chk($sformatf("lat%0d", k), n, nbusy(k) + 1);
        res = os[k];
        for (int i = 0; i < stall; i++) begin
            step;
            chk($sformatf("hold_v%0d", k), ov[k], 1);
            chk($sformatf("hold_d%0d", k), os[k], res);
            chk($sformatf("hold_r%0d", k), ir[k], 0);
        end
        ordy[k] = 1;
        step;
        chk($sformatf("xfer%0d", k), ov[k], 0);
    endtask

    task automatic b2b(input int k);
        logic [127:0] sin[4], sexp[4];
        int n, last_acc;
        sin  = '{VX, VY, VX, VY};
        sexp = '{VY, VX, VY, VX};
        last_acc = 0;
        ordy[k] = 1;
        for (int t = 0; t < 4; t++) begin
            iv[k] = 1; is_[k] = sin[t]; ii[k] = t[0];
            n = 0;
            while (!ir[k] && n < 20) begin step; n++; end
            if (t > 0) begin
                chk($sformatf("b2b_v%0d", k), ov[k], 1);
                chk($sformatf("b2b_d%0d_%0d", k, t - 1), os[k], sexp[t - 1]);
                chk($sformatf("b2b_gap%0d", k), cyc - last_acc, nbusy(k) + 1);
            end
            last_acc = cyc;
            step;
        end
        iv[k] = 0;
        n = 0;
        while (!ov[k] && n < 20) begin step; n++; end
        chk($sformatf("b2b_d%0d_3", k), os[k], sexp[3]);
        step;
        chk($sformatf("b2b_end%0d", k), ov[k], 0);
    endtask

    initial begin
        logic [127:0] r, x, y;
        checks = 0; errors = 0; cyc = 0;
        rst_n = 0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 0; ii[k] = 0; ordy[k] = 0; is_[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_ov%0d", k), ov[k], 0);
            chk($sformatf("rst_bz%0d", k), bz[k], 0);
            chk($sformatf("rst_os%0d", k), os[k], 0);
            chk($sformatf("rst_ir%0d", k), ir[k], 0);
        end
        rst_n = 1;
        #1;
        chk("ir_before_edge", ir[0], 0);
        step;
        for (int k = 0; k < 4; k++) chk($sformatf("ir_after%0d", k), ir[k], 1);

        for (int k = 0; k < 3; k++) begin
            run(k, VX, 1'b0, 0, r); chk($sformatf("fwd%0d", k), r, VY);
            run(k, VY, 1'b1, 0, r); chk($sformatf("inv%0d", k), r, VX);
        end
        run(1, VZ, 1'b0, 0, r); chk("fwd_z", r, VW);
        run(2, VW, 1'b1, 0, r); chk("inv_z", r, VZ);
        run(3, VX, 1'b1, 0, r); chk("noinv_m1", r, VY);
        run(3, VX, 1'b0, 0, r); chk("noinv_m0", r, VY);

        run(1, VX, 1'b0, 10, r); chk("bp_data", r, VY);
        chk("bp_idle", ir[1], 1);

        b2b(0);
        b2b(2);

        // reset one cycle into BUSY discards the transaction
        iv[0] = 1; is_[0] = VX; ii[0] = 0; ordy[0] = 1;
        step;
        iv[0] = 0;
        step;
        chk("mid_busy", bz[0], 1);
        rst_n = 0;
        #1;
        chk("mr_ov", ov[0], 0);
        chk("mr_bz", bz[0], 0);
        chk("mr_os", os[0], 0);
        chk("mr_ir", ir[0], 0);
        step; step;
        rst_n = 1;
        step;
        chk("mr_ir_up", ir[0], 1);
        repeat (6) begin step; chk("mr_stale", ov[0], 0); end
        run(0, VC, 1'b0, 0, r); chk("mr_c6", r, VC);

        for (int i = 0; i < 40; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            run(i % 3, x, 1'b0, $urandom_range(0, 3), y);
            run(i % 3, y, 1'b1, $urandom_range(0, 3), r);
            chk($sformatf("rt%0d", i), r, x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, 1, number of state columns transformed per clock; legal values 1, 2, 4.
REQ-002 SHALL have parameter INVERSE_EN, 1, when 1 enables the inverse (decrypt) matrix; when 0 the mode input is ignored and only the forward matrix is built.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  in_state/in_inverse hold a transaction.
REQ-006 SHALL have port in_ready  output  1  engine accepts a transaction this cycle.
REQ-007 SHALL have port in_state  input  state_t (128)  AES state; byte i = bits [127-8i -: 8]; column c = bytes 4c..4c+3.
REQ-008 SHALL have port in_inverse  input  1  0 = forward matrix (2 3 1 1 circulant), 1 = inverse matrix (14 11 13 9 circulant).
REQ-009 SHALL have port out_valid  output  1  out_state holds a completed result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes result this cycle.
REQ-011 SHALL have port out_state  output  state_t (128)  transformed state, same byte/column ordering as in_state.
REQ-012 SHALL have port busy  output  1  high while in state BUSY.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL drive in_ready = 1 in IDLE, and in DONE only when out_ready = 1; 0 in BUSY.
REQ-015 SHALL accept a transaction when in_valid && in_ready: capture in_state into working register, latch mode (in_inverse && INVERSE_EN), clear column counter, go to BUSY.
REQ-016 SHALL, each BUSY cycle, replace COLS_PER_CYCLE consecutive columns starting at column counter with their GF(2^8) product (reduction polynomial 0x11B) under the latched matrix, then advance counter by COLS_PER_CYCLE.
REQ-017 SHALL leave BUSY for DONE on the cycle the last column group is written; BUSY lasts exactly 4/COLS_PER_CYCLE cycles.
REQ-018 SHALL assert out_valid only in DONE; out_state equals working register and is stable while out_valid && !out_ready.
REQ-019 SHALL, in DONE with out_ready = 1 and no new accept, return to IDLE; with out_ready = 1 and in_valid = 1 accept the new transaction and go directly to BUSY (back-to-back, no bubble in IDLE).
REQ-020 SHALL give accept-to-out_valid latency of 4/COLS_PER_CYCLE + 1 cycles; sustained throughput one state per 4/COLS_PER_CYCLE + 1 cycles.
REQ-021 SHALL ignore in_state/in_inverse changes after acceptance; mode is per transaction.
REQ-022 SHALL ignore out_ready outside DONE and in_valid while in_ready = 0.
REQ-023 SHALL, for INVERSE_EN = 0, process every transaction with forward matrix regardless of in_inverse.
REQ-024 SHALL reject illegal COLS_PER_CYCLE at elaboration.

Reset
REQ-025 SHALL, on reset_n low (any state, including mid-BUSY), asynchronously force FSM to IDLE, column counter 0, working register 0, latched mode 0.
REQ-026 SHALL drive out_valid = 0, busy = 0, out_state = 0, in_ready = 0 while reset_n low; in_ready = 1 from first clock edge after reset_n high.
REQ-027 SHALL discard a transaction in progress at reset; no result is produced for it.

Verification
REQ-028 Forward: columns db135345, f20a225c, 01010101, 2d26314c, in_inverse=0 -> out_state 8e4da1bc 9fdc589d 01010101 4d7ebdf8, out_valid after 4/COLS_PER_CYCLE+1 cycles, for COLS_PER_CYCLE 1, 2, 4.
REQ-029 Inverse: out_state of REQ-028 with in_inverse=1 -> db135345 f20a225c 01010101 2d26314c; INVERSE_EN=0 instance with same stimulus -> forward result.
REQ-030 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid high, out_state stable, in_ready 0; release -> exactly one transfer.
REQ-031 Back-to-back: in_valid constant high, alternating modes, out_ready=1 -> one result per 4/COLS_PER_CYCLE+1 cycles, no IDLE cycle, each result matches its own mode.
REQ-032 Reset mid-BUSY: reset_n low 1 cycle after accept -> out_valid 0, busy 0 immediately; after release new transaction c6c6c6c6 x4 forward -> c6c6c6c6 x4, no stale output.
REQ-033 Random: 10k random states/modes with random in_valid/out_ready stalls vs software model -> zero mismatches, forward then inverse round-trip identity.
